// File: rtl/axi_lite_slave_mem_if.sv
// AXI-lite bus bundle for the slave memory: AW/W/B write channels and AR/R read channels.
// The master modport is the bus initiator; the slave modport is the memory side.
interface axi_lite_slave_mem_if #(
   parameter int DATA_WD = 32,
   parameter int ADDR_WD = 12
);
   logic                   awvalid;
   logic                   awready;
   logic [ADDR_WD-1:0]     awaddr;
   logic                   wvalid;
   logic                   wready;
   logic [DATA_WD-1:0]     wdata;
   logic [DATA_WD/8-1:0]   wstrb;
   logic                   bvalid;
   logic                   bready;
   logic [1:0]             brsp;
   logic                   arvalid;
   logic                   arready;
   logic [ADDR_WD-1:0]     araddr;
   logic                   rvalid;
   logic                   rready;
   logic [DATA_WD-1:0]     rdata;
   logic [1:0]             rrsp;

   modport master (
      output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      input  awready, wready, bvalid, brsp, arready, rvalid, rdata, rrsp
   );

   modport slave (
      input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      output awready, wready, bvalid, brsp, arready, rvalid, rdata, rrsp
   );
endinterface

// File: rtl/axi_lite_slave_mem.sv
// AXI-lite slave scratch memory: byte-strobed writes with independent AW/W holders,
// DECERR/SLVERR classification, and a single-cycle pipelined read channel.
module axi_lite_slave_mem #(
   parameter int DATA_WD  = 32,
   parameter int ADDR_WD  = 12,
   parameter int DEPTH    = 64,
   parameter int RO_WORDS = 0
) (
   input logic                 clk,
   input logic                 rst,
   axi_lite_slave_mem_if.slave bus
);
   localparam int STRB_WD    = DATA_WD / 8;
   localparam int LSB        = $clog2(STRB_WD);
   localparam int IDX_WD     = ADDR_WD - LSB;
   localparam int MEM_IDX_WD = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      RSP_OKAY   = 2'b00,
      RSP_SLVERR = 2'b10,
      RSP_DECERR = 2'b11
   } rsp_e;

   logic [DATA_WD-1:0] mem [DEPTH];

   logic               aw_held;
   logic [IDX_WD-1:0]  aw_idx_q;
   logic               w_held;
   logic [DATA_WD-1:0] w_data_q;
   logic [STRB_WD-1:0] w_strb_q;
   logic               bvalid_q;
   rsp_e               brsp_q;
   logic               rvalid_q;
   logic [DATA_WD-1:0] rdata_q;
   rsp_e               rrsp_q;

   logic               aw_rdy;
   logic               w_rdy;
   logic               ar_rdy;
   logic               aw_fire;
   logic               w_fire;
   logic               ar_fire;
   logic               commit;
   logic [IDX_WD-1:0]  w_idx;
   logic [DATA_WD-1:0] w_data;
   logic [STRB_WD-1:0] w_strb;
   logic [IDX_WD-1:0]  r_idx;
   logic               w_oor;
   logic               w_prot;
   logic               r_oor;
   rsp_e               w_rsp;

   // Readies come only from registered state plus the response-side ready inputs.
   assign aw_rdy  = !aw_held && (!bvalid_q || bus.bready);
   assign w_rdy   = !w_held && (!bvalid_q || bus.bready);
   assign ar_rdy  = !rvalid_q || bus.rready;

   assign aw_fire = bus.awvalid && aw_rdy;
   assign w_fire  = bus.wvalid && w_rdy;
   assign ar_fire = bus.arvalid && ar_rdy;

   assign bus.awready = aw_rdy;
   assign bus.wready  = w_rdy;
   assign bus.arready = ar_rdy;
   assign bus.bvalid  = bvalid_q;
   assign bus.brsp    = brsp_q;
   assign bus.rvalid  = rvalid_q;
   assign bus.rdata   = rdata_q;
   assign bus.rrsp    = rrsp_q;

   always_comb begin
      w_idx  = aw_held ? aw_idx_q : bus.awaddr[ADDR_WD-1:LSB];
      w_data = w_held ? w_data_q : bus.wdata;
      w_strb = w_held ? w_strb_q : bus.wstrb;
      r_idx  = bus.araddr[ADDR_WD-1:LSB];
      commit = (aw_fire || aw_held) && (w_fire || w_held);
   end

   // Range checks collapse to constants when the whole index space is backed or nothing is protected.
   if (DEPTH < (1 << IDX_WD)) begin : g_range
      assign w_oor = ({1'b0, w_idx} >= (IDX_WD+1)'(DEPTH));
      assign r_oor = ({1'b0, r_idx} >= (IDX_WD+1)'(DEPTH));
   end else begin : g_full
      assign w_oor = 1'b0;
      assign r_oor = 1'b0;
   end

   if (RO_WORDS > 0) begin : g_prot
      assign w_prot = ({1'b0, w_idx} < (IDX_WD+1)'(RO_WORDS));
   end else begin : g_noprot
      assign w_prot = 1'b0;
   end

   always_comb begin
      w_rsp = RSP_OKAY;
      if (w_oor) begin
         w_rsp = RSP_DECERR;
      end else if (w_prot) begin
         w_rsp = RSP_SLVERR;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         aw_held  <= 1'b0;
         aw_idx_q <= '0;
         w_held   <= 1'b0;
         w_data_q <= '0;
         w_strb_q <= '0;
         bvalid_q <= 1'b0;
         brsp_q   <= RSP_OKAY;
      end else begin
         if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
         end else begin
            if (aw_fire) begin
               aw_held  <= 1'b1;
               aw_idx_q <= bus.awaddr[ADDR_WD-1:LSB];
            end
            if (w_fire) begin
               w_held   <= 1'b1;
               w_data_q <= bus.wdata;
               w_strb_q <= bus.wstrb;
            end
         end
         // A new commit overrides a concurrent B handshake so bvalid never drops between them.
         if (commit) begin
            bvalid_q <= 1'b1;
            brsp_q   <= w_rsp;
         end else if (bus.bready) begin
            bvalid_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (commit && (w_rsp == RSP_OKAY)) begin
         for (int b = 0; b < STRB_WD; b++) begin
            if (w_strb[b]) begin
               mem[w_idx[MEM_IDX_WD-1:0]][8*b +: 8] <= w_data[8*b +: 8];
            end
         end
      end
   end

   // Memory is sampled before the same-edge write lands, so a colliding read sees old data.
   always_ff @(posedge clk) begin
      if (rst) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rrsp_q   <= RSP_OKAY;
      end else if (ar_fire) begin
         rvalid_q <= 1'b1;
         if (r_oor) begin
            rdata_q <= '0;
            rrsp_q  <= RSP_DECERR;
         end else begin
            rdata_q <= mem[r_idx[MEM_IDX_WD-1:0]];
            rrsp_q  <= RSP_OKAY;
         end
      end else if (bus.rready) begin
         rvalid_q <= 1'b0;
      end
   end
endmodule

// File: doc/axi_lite_slave_mem.md
# axi_lite_slave_mem

Parametrised AXI-lite slave memory with byte write strobes, independent AW/W capture, out-of-range and write-protect error responses, and a fully pipelined read channel. It is the next generation of the team's AXI-lite register/memory slave, sitting behind an AXI-lite master or interconnect as a small register file or scratch RAM. Storage is flop-based and cleared by reset.

## Interface
- DATA_WD, 32, data width in bits; multiple of 8, minimum 8.
- ADDR_WD, 12, byte address width.
- DEPTH, 64, number of DATA_WD words; must satisfy DEPTH <= 2^(ADDR_WD-LSB).
- RO_WORDS, 0, words [0, RO_WORDS) are write-protected; 0 disables protection.
- Derived: LSB = log2(DATA_WD/8); word index = addr[ADDR_WD-1:LSB]; addr[LSB-1:0] ignored.
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- awvalid / awready  input / output  1  write address handshake.
- awaddr  input  ADDR_WD  write byte address.
- wvalid / wready  input / output  1  write data handshake.
- wdata  input  DATA_WD  write data.
- wstrb  input  DATA_WD/8  byte enables; bit i gates wdata[8i+7:8i].
- bvalid / bready  output / input  1  write response handshake.
- brsp  output  2  write response: 2'b00 OKAY, 2'b10 SLVERR, 2'b11 DECERR.
- arvalid / arready  input / output  1  read address handshake.
- araddr  input  ADDR_WD  read byte address.
- rvalid / rready  output / input  1  read data handshake.
- rdata  output  DATA_WD  read data.
- rrsp  output  2  read response, same encoding as brsp.

## Operation
- Reset: every storage word, the AW/W holding registers and all outputs cleared; bvalid=0, brsp=0, rvalid=0, rdata=0, rrsp=0; awready=wready=arready=1 in the first cycle after reset deassertion.
- Fire = valid && ready on a channel.
- AW and W captured independently: each has a one-entry holding register (held flag plus payload). awready = !aw_held && (!bvalid || bready); wready = !w_held && (!bvalid || bready).
- Write commits in the cycle where address (aw_fire or aw_held) and data (w_fire or w_held) are both available; live inputs take precedence over empty holders. On commit, both held flags clear and bvalid is set next cycle.
- Commit classification: index >= DEPTH gives DECERR with no storage change; index < RO_WORDS gives SLVERR with no storage change; otherwise OKAY, and only bytes with wstrb=1 update. A wstrb of 0 is OKAY with no change.
- A fire with no partner loads the holder. The holder persists until its partner arrives; there is no timeout.
- bvalid, once set, holds with brsp stable until b_fire. If b_fire and a new commit occur in the same cycle, bvalid stays 1 and brsp takes the new value.
- Read: on ar_fire, rdata/rrsp/rvalid are registered next cycle. arready = !rvalid || rready, so reads run back-to-back at one per cycle.
- Out-of-range read gives rdata=0, rrsp=DECERR. Read-protected words read normally with OKAY.
- rvalid, rdata and rrsp hold stable while rvalid && !rready.
- Read and write commit to the same word in the same cycle: the read returns the pre-write data.

## Timing
- Write latency: AW and W firing together gives bvalid in the next cycle. When split, bvalid follows one cycle after the later fire.
- Read latency: 1 cycle from ar_fire to rvalid. Sustained throughput is 1 read per cycle with rready held high.
- Write throughput: 1 write per cycle while bready is held high.
- rst asserted mid-transaction: everything is cleared the next cycle. Held AW/W and pending B/R are discarded, with no response issued.
- No combinational path from any valid input to any ready output. Ready outputs depend only on registered state and on bready/rready.

## Test plan
Parameters: DATA_WD=32, ADDR_WD=12, DEPTH=64, RO_WORDS=2.
- Reset, then simultaneous AW 0x010 and W 0xDEADBEEF with wstrb=4'hF. Expect bvalid next cycle with brsp=00. A subsequent AR 0x010 gives rvalid one cycle after ar_fire with rdata=0xDEADBEEF and rrsp=00.
- Send W 0x11223344 with wstrb=4'b0101 three cycles before AW 0x010. Expect wready=0 while held, bvalid the cycle after aw_fire, and readback 0xDE22BE44.
- AW 0x004 (word 1, protected) with data 0xFFFFFFFF gives brsp=SLVERR and word 1 stays 0. AW 0x100 (index 64) gives brsp=DECERR. AR 0x100 gives rdata=0 and rrsp=DECERR.
- Hold bready=0 after a completed write. Expect awready=wready=0 and bvalid/brsp stable. Raising bready while a new AW+W is presented completes both, and bvalid stays 1 continuously.
- Back-to-back ARs to words 2..5 with rready toggling 1,0,1,1. Expect no lost or duplicated beat, rdata stable during the stall, and arready low only while rvalid && !rready.
- Write 0xA5A5A5A5 to word 3 while simultaneously reading word 3 (previous value 0). Expect rdata=0, and a later read returns 0xA5A5A5A5. Asserting rst with a held AW clears bvalid/rvalid, and all words read 0 afterwards.
